// File: rtl/dvp_conf_pkg.sv
// Shared definitions for the DVP configuration master.
//   state_e      : FSM state encodings
//   RESP_*       : response codes returned to the local controller
//   REG_*_OFS    : DVP register byte offsets
//   tmr_width()  : watchdog counter width for a given cycle limit
package dvp_conf_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR_REQ  = 3'd1,
        ST_WR_RESP = 3'd2,
        ST_RD_REQ  = 3'd3,
        ST_RD_RESP = 3'd4,
        ST_RSP     = 3'd5,
        ST_HALT    = 3'd6
    } state_e;

    localparam logic [1:0] RESP_OK     = 2'b00;
    localparam logic [1:0] RESP_TMO    = 2'b10;
    localparam logic [1:0] RESP_MAPERR = 2'b11;

    localparam logic [31:0] REG_STATUS_OFS  = 32'h0000_0000;
    localparam logic [31:0] REG_SCALER_OFS  = 32'h0000_0004;
    localparam logic [31:0] REG_PIXBASE_OFS = 32'h0000_0008;

    // A disabled watchdog (limit 0) still gets a 1-bit counter so no zero-width vector appears.
    function automatic int unsigned tmr_width(input int unsigned limit);
        return (limit > 0) ? $clog2(limit + 1) : 1;
    endfunction

endpackage

// File: rtl/conf_txn_timer.sv
// Transaction watchdog counter.
//   clk, rst_n : clock, async active-low reset
//   clr        : restart the count (priority over en)
//   en         : count this cycle
//   expire     : combinational; high in the cycle whose increment reaches TIMEOUT_CYC
module conf_txn_timer
    import dvp_conf_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 256
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam int unsigned CNT_W = tmr_width(TIMEOUT_CYC);
    localparam int unsigned LIMIT = (TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0;
    localparam bit          ARMED = (TIMEOUT_CYC > 0);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Fire one cycle early so the FSM lands in RSP on the edge the count reaches the limit.
    assign expire = ARMED && en && (cnt_q == CNT_W'(LIMIT));

endmodule

// File: rtl/dvp_config_master.sv
// AXI4 single-beat register initiator for the DVP/scaler subsystem.
//   cmd_*   : command from the local controller (valid/ready)
//   rsp_*   : response to the controller (valid/ready), held stable until accepted
//   m_aw*/m_w*/m_b* : AXI write channels
//   m_ar*/m_r*      : AXI read channels
//   timeout_err_o   : sticky watchdog flag; the block halts until reset
module dvp_config_master
    import dvp_conf_pkg::*;
#(
    parameter int unsigned ADDR_W       = 32,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned MST_ID_W     = 5,
    parameter int unsigned MST_ID       = 0,
    parameter int unsigned TRANS_RESP_W = 2,
    parameter int unsigned TIMEOUT_CYC  = 256
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    cmd_valid_i,
    output logic                    cmd_ready_o,
    input  logic                    cmd_wr_i,
    input  logic [ADDR_W-1:0]       cmd_addr_i,
    input  logic [DATA_W-1:0]       cmd_wdata_i,
    output logic                    rsp_valid_o,
    input  logic                    rsp_ready_i,
    output logic                    rsp_wr_o,
    output logic [DATA_W-1:0]       rsp_rdata_o,
    output logic [TRANS_RESP_W-1:0] rsp_resp_o,
    output logic [MST_ID_W-1:0]     m_awid_o,
    output logic [ADDR_W-1:0]       m_awaddr_o,
    output logic                    m_awvalid_o,
    input  logic                    m_awready_i,
    output logic [DATA_W-1:0]       m_wdata_o,
    output logic                    m_wvalid_o,
    input  logic                    m_wready_i,
    input  logic [TRANS_RESP_W-1:0] m_bresp_i,
    input  logic                    m_bvalid_i,
    output logic                    m_bready_o,
    output logic [MST_ID_W-1:0]     m_arid_o,
    output logic [ADDR_W-1:0]       m_araddr_o,
    output logic                    m_arvalid_o,
    input  logic                    m_arready_i,
    input  logic [DATA_W-1:0]       m_rdata_i,
    input  logic                    m_rvalid_i,
    output logic                    m_rready_o,
    output logic                    timeout_err_o
);

    state_e                  state_q,       state_d;
    logic [ADDR_W-1:0]       addr_q,        addr_d;
    logic [DATA_W-1:0]       wdata_q,       wdata_d;
    logic                    awvalid_q,     awvalid_d;
    logic                    wvalid_q,      wvalid_d;
    logic                    arvalid_q,     arvalid_d;
    logic                    rsp_valid_q,   rsp_valid_d;
    logic                    rsp_wr_q,      rsp_wr_d;
    logic [DATA_W-1:0]       rsp_rdata_q,   rsp_rdata_d;
    logic [TRANS_RESP_W-1:0] rsp_resp_q,    rsp_resp_d;
    logic                    timeout_err_q, timeout_err_d;

    logic tmr_clr_c;
    logic tmr_en_c;
    logic tmr_expire_c;
    logic abort_c;
    logic aw_done_c;
    logic w_done_c;

    conf_txn_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (tmr_clr_c),
        .en     (tmr_en_c),
        .expire (tmr_expire_c)
    );

    // Per-channel completion for the write request phase (already done, or handshaking now)
    assign aw_done_c = !awvalid_q || m_awready_i;
    assign w_done_c  = !wvalid_q  || m_wready_i;

    // Next-state and registered-output logic
    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        awvalid_d     = awvalid_q;
        wvalid_d      = wvalid_q;
        arvalid_d     = arvalid_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_wr_d      = rsp_wr_q;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_resp_d    = rsp_resp_q;
        timeout_err_d = timeout_err_q;
        tmr_clr_c     = 1'b0;
        tmr_en_c      = 1'b0;
        abort_c       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid_i) begin
                    tmr_clr_c = 1'b1;
                    addr_d    = cmd_addr_i;
                    wdata_d   = cmd_wdata_i;
                    rsp_wr_d  = cmd_wr_i;
                    if (cmd_wr_i) begin
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        state_d   = ST_WR_REQ;
                    end else begin
                        arvalid_d = 1'b1;
                        state_d   = ST_RD_REQ;
                    end
                end
            end
            ST_WR_REQ: begin
                tmr_en_c = 1'b1;
                if (m_awready_i) awvalid_d = 1'b0;
                if (m_wready_i)  wvalid_d  = 1'b0;
                if (aw_done_c && w_done_c) begin
                    state_d = ST_WR_RESP;
                end else begin
                    abort_c = tmr_expire_c;
                end
            end
            ST_WR_RESP: begin
                tmr_en_c = 1'b1;
                if (m_bvalid_i) begin
                    rsp_resp_d  = m_bresp_i;
                    rsp_rdata_d = '0;
                    rsp_valid_d = 1'b1;
                    state_d     = ST_RSP;
                end else begin
                    abort_c = tmr_expire_c;
                end
            end
            ST_RD_REQ: begin
                tmr_en_c = 1'b1;
                if (m_arready_i) begin
                    arvalid_d = 1'b0;
                    state_d   = ST_RD_RESP;
                end else begin
                    abort_c = tmr_expire_c;
                end
            end
            ST_RD_RESP: begin
                tmr_en_c = 1'b1;
                if (m_rvalid_i) begin
                    rsp_rdata_d = m_rdata_i;
                    rsp_resp_d  = TRANS_RESP_W'(RESP_OK);
                    rsp_valid_d = 1'b1;
                    state_d     = ST_RSP;
                end else begin
                    abort_c = tmr_expire_c;
                end
            end
            ST_RSP: begin
                if (rsp_ready_i) begin
                    rsp_valid_d = 1'b0;
                    state_d     = timeout_err_q ? ST_HALT : ST_IDLE;
                end
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Watchdog abort: withdraw every request and report a timeout
        if (abort_c) begin
            awvalid_d     = 1'b0;
            wvalid_d      = 1'b0;
            arvalid_d     = 1'b0;
            rsp_resp_d    = TRANS_RESP_W'(RESP_TMO);
            rsp_rdata_d   = '0;
            rsp_valid_d   = 1'b1;
            timeout_err_d = 1'b1;
            state_d       = ST_RSP;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            addr_q        <= '0;
            wdata_q       <= '0;
            awvalid_q     <= 1'b0;
            wvalid_q      <= 1'b0;
            arvalid_q     <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_wr_q      <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_resp_q    <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            awvalid_q     <= awvalid_d;
            wvalid_q      <= wvalid_d;
            arvalid_q     <= arvalid_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_wr_q      <= rsp_wr_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_resp_q    <= rsp_resp_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    // Handshake readies are pure state decodes
    assign cmd_ready_o   = (state_q == ST_IDLE);
    assign m_bready_o    = (state_q == ST_WR_RESP);
    assign m_rready_o    = (state_q == ST_RD_RESP);

    assign m_awid_o      = MST_ID_W'(MST_ID);
    assign m_arid_o      = MST_ID_W'(MST_ID);
    assign m_awaddr_o    = addr_q;
    assign m_araddr_o    = addr_q;
    assign m_wdata_o     = wdata_q;
    assign m_awvalid_o   = awvalid_q;
    assign m_wvalid_o    = wvalid_q;
    assign m_arvalid_o   = arvalid_q;
    assign rsp_valid_o   = rsp_valid_q;
    assign rsp_wr_o      = rsp_wr_q;
    assign rsp_rdata_o   = rsp_rdata_q;
    assign rsp_resp_o    = rsp_resp_q;
    assign timeout_err_o = timeout_err_q;

endmodule

// File: tb/tb_dvp_config_master.sv
// Scoreboard bench for dvp_config_master: the stimulus process pushes expected
// responses, a monitor process pops and compares on each response handshake.
module tb_dvp_config_master;
    import dvp_conf_pkg::*;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned IDW    = 5;
    localparam int unsigned RW     = 2;
    localparam int unsigned TMO    = 16;
    localparam logic [31:0] BASE   = 32'h4000_0000;

    typedef struct packed {
        logic        wr;
        logic [31:0] rdata;
        logic [1:0]  resp;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              cmd_valid_i, cmd_ready_o, cmd_wr_i;
    logic [ADDR_W-1:0] cmd_addr_i;
    logic [DATA_W-1:0] cmd_wdata_i;
    logic              rsp_valid_o, rsp_ready_i, rsp_wr_o;
    logic [DATA_W-1:0] rsp_rdata_o;
    logic [RW-1:0]     rsp_resp_o;
    logic [IDW-1:0]    m_awid_o, m_arid_o;
    logic [ADDR_W-1:0] m_awaddr_o, m_araddr_o;
    logic              m_awvalid_o, m_awready_i;
    logic [DATA_W-1:0] m_wdata_o;
    logic              m_wvalid_o, m_wready_i;
    logic [RW-1:0]     m_bresp_i;
    logic              m_bvalid_i, m_bready_o;
    logic              m_arvalid_o, m_arready_i;
    logic [DATA_W-1:0] m_rdata_i;
    logic              m_rvalid_i, m_rready_o;
    logic              timeout_err_o;

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];

    dvp_config_master #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MST_ID_W(IDW), .MST_ID(0),
        .TRANS_RESP_W(RW), .TIMEOUT_CYC(TMO)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_wr_i(cmd_wr_i),
        .cmd_addr_i(cmd_addr_i), .cmd_wdata_i(cmd_wdata_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_wr_o(rsp_wr_o),
        .rsp_rdata_o(rsp_rdata_o), .rsp_resp_o(rsp_resp_o),
        .m_awid_o(m_awid_o), .m_awaddr_o(m_awaddr_o), .m_awvalid_o(m_awvalid_o),
        .m_awready_i(m_awready_i),
        .m_wdata_o(m_wdata_o), .m_wvalid_o(m_wvalid_o), .m_wready_i(m_wready_i),
        .m_bresp_i(m_bresp_i), .m_bvalid_i(m_bvalid_i), .m_bready_o(m_bready_o),
        .m_arid_o(m_arid_o), .m_araddr_o(m_araddr_o), .m_arvalid_o(m_arvalid_o),
        .m_arready_i(m_arready_i),
        .m_rdata_i(m_rdata_i), .m_rvalid_i(m_rvalid_i), .m_rready_o(m_rready_o),
        .timeout_err_o(timeout_err_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a command; returns in cycle 1 (one cycle after the accepting edge)
    task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] data);
        cmd_valid_i = 1'b1;
        cmd_wr_i    = wr;
        cmd_addr_i  = addr;
        cmd_wdata_i = data;
        chk("cmd_ready_before_accept", 64'(cmd_ready_o), 64'd1);
        step();
        cmd_valid_i = 1'b0;
        cmd_wr_i    = 1'b0;
        cmd_addr_i  = '0;
        cmd_wdata_i = '0;
    endtask

    // Response monitor
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rsp_valid_o === 1'b1 && rsp_ready_i === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_rsp", 64'(rsp_valid_o), 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("rsp_wr",    64'(rsp_wr_o),    64'(e.wr));
                    chk("rsp_rdata", 64'(rsp_rdata_o), 64'(e.rdata));
                    chk("rsp_resp",  64'(rsp_resp_o),  64'(e.resp));
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        cmd_valid_i = 1'b0; cmd_wr_i = 1'b0; cmd_addr_i = '0; cmd_wdata_i = '0;
        rsp_ready_i = 1'b1;
        m_awready_i = 1'b0; m_wready_i = 1'b0; m_arready_i = 1'b0;
        m_bresp_i = '0; m_bvalid_i = 1'b0; m_rdata_i = '0; m_rvalid_i = 1'b0;

        // Reset state
        #3;
        chk("rst_cmd_ready",  64'(cmd_ready_o),   64'd1);
        chk("rst_awvalid",    64'(m_awvalid_o),   64'd0);
        chk("rst_wvalid",     64'(m_wvalid_o),    64'd0);
        chk("rst_arvalid",    64'(m_arvalid_o),   64'd0);
        chk("rst_rsp_valid",  64'(rsp_valid_o),   64'd0);
        chk("rst_bready",     64'(m_bready_o),    64'd0);
        chk("rst_rready",     64'(m_rready_o),    64'd0);
        chk("rst_timeout",    64'(timeout_err_o), 64'd0);
        chk("rst_awaddr",     64'(m_awaddr_o),    64'd0);
        chk("rst_rdata",      64'(rsp_rdata_o),   64'd0);
        #19 rst_n = 1'b1;
        step();

        // Immediate-ready write
        m_awready_i = 1'b1; m_wready_i = 1'b1;
        exp_q.push_back('{wr: 1'b1, rdata: 32'h0, resp: RESP_OK});
        issue(1'b1, BASE | REG_SCALER_OFS, 32'h0000_1234);
        chk("w1_awvalid_c1", 64'(m_awvalid_o), 64'd1);
        chk("w1_wvalid_c1",  64'(m_wvalid_o),  64'd1);
        chk("w1_awaddr",     64'(m_awaddr_o),  64'h4000_0004);
        chk("w1_wdata",      64'(m_wdata_o),   64'h0000_1234);
        chk("w1_awid",       64'(m_awid_o),    64'd0);
        step();
        m_awready_i = 1'b0; m_wready_i = 1'b0; m_bvalid_i = 1'b1; m_bresp_i = RESP_OK;
        chk("w1_bready_c2",    64'(m_bready_o),  64'd1);
        chk("w1_awvalid_c2",   64'(m_awvalid_o), 64'd0);
        chk("w1_rsp_valid_c2", 64'(rsp_valid_o), 64'd0);
        step();
        m_bvalid_i = 1'b0;
        chk("w1_rsp_valid_c3", 64'(rsp_valid_o), 64'd1);
        step();

        // Write with AW delayed three cycles
        m_wready_i = 1'b1;
        exp_q.push_back('{wr: 1'b1, rdata: 32'h0, resp: RESP_OK});
        issue(1'b1, BASE | REG_SCALER_OFS, 32'h0000_5678);
        chk("w2_wvalid_c1", 64'(m_wvalid_o), 64'd1);
        step();
        m_wready_i = 1'b0;
        for (int c = 2; c <= 4; c++) begin
            if (c == 4) m_awready_i = 1'b1;
            chk("w2_awvalid_hold", 64'(m_awvalid_o), 64'd1);
            chk("w2_wvalid_low",   64'(m_wvalid_o),  64'd0);
            chk("w2_awaddr_hold",  64'(m_awaddr_o),  64'h4000_0004);
            step();
        end
        m_awready_i = 1'b0; m_bvalid_i = 1'b1; m_bresp_i = RESP_OK;
        chk("w2_awvalid_c5", 64'(m_awvalid_o), 64'd0);
        chk("w2_bready_c5",  64'(m_bready_o),  64'd1);
        step();
        m_bvalid_i = 1'b0;
        chk("w2_rsp_valid", 64'(rsp_valid_o), 64'd1);
        step();

        // Read
        m_arready_i = 1'b1;
        exp_q.push_back('{wr: 1'b0, rdata: 32'hDEAD_BEEF, resp: RESP_OK});
        issue(1'b0, BASE | REG_PIXBASE_OFS, 32'h0);
        chk("r1_arvalid_c1", 64'(m_arvalid_o), 64'd1);
        chk("r1_araddr",     64'(m_araddr_o),  64'h4000_0008);
        chk("r1_awvalid",    64'(m_awvalid_o), 64'd0);
        step();
        m_arready_i = 1'b0; m_rvalid_i = 1'b1; m_rdata_i = 32'hDEAD_BEEF;
        chk("r1_rready_c2",  64'(m_rready_o),  64'd1);
        chk("r1_arvalid_c2", 64'(m_arvalid_o), 64'd0);
        step();
        m_rvalid_i = 1'b0; m_rdata_i = '0;
        chk("r1_rsp_valid_c3", 64'(rsp_valid_o), 64'd1);
        step();

        // Map error write
        m_awready_i = 1'b1; m_wready_i = 1'b1;
        exp_q.push_back('{wr: 1'b1, rdata: 32'h0, resp: RESP_MAPERR});
        issue(1'b1, 32'h4000_0010, 32'h0000_CAFE);
        step();
        m_awready_i = 1'b0; m_wready_i = 1'b0; m_bvalid_i = 1'b1; m_bresp_i = RESP_MAPERR;
        step();
        m_bvalid_i = 1'b0; m_bresp_i = RESP_OK;
        chk("me_rsp_valid", 64'(rsp_valid_o), 64'd1);
        step();
        chk("me_back_idle", 64'(cmd_ready_o), 64'd1);

        // Response backpressure
        rsp_ready_i = 1'b0; m_arready_i = 1'b1;
        exp_q.push_back('{wr: 1'b0, rdata: 32'h0000_00A5, resp: RESP_OK});
        issue(1'b0, BASE | REG_STATUS_OFS, 32'h0);
        step();
        m_arready_i = 1'b0; m_rvalid_i = 1'b1; m_rdata_i = 32'h0000_00A5;
        step();
        m_rvalid_i = 1'b0; m_rdata_i = 32'hFFFF_FFFF;
        for (int c = 0; c < 5; c++) begin
            chk("bp_rsp_valid", 64'(rsp_valid_o), 64'd1);
            chk("bp_rdata",     64'(rsp_rdata_o), 64'h0000_00A5);
            chk("bp_wr",        64'(rsp_wr_o),    64'd0);
            chk("bp_resp",      64'(rsp_resp_o),  64'(RESP_OK));
            chk("bp_cmd_ready", 64'(cmd_ready_o), 64'd0);
            step();
        end
        rsp_ready_i = 1'b1; m_rdata_i = '0;
        chk("bp_rsp_valid_last", 64'(rsp_valid_o), 64'd1);
        step();
        chk("bp_rsp_done",   64'(rsp_valid_o), 64'd0);
        chk("bp_cmd_ready1", 64'(cmd_ready_o), 64'd1);

        // Reset during WR_REQ (transaction dropped, no response expected)
        issue(1'b1, BASE | REG_SCALER_OFS, 32'h0000_0099);
        chk("rs_awvalid_pre", 64'(m_awvalid_o), 64'd1);
        chk("rs_cmd_ready_pre", 64'(cmd_ready_o), 64'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("rs_awvalid_async", 64'(m_awvalid_o), 64'd0);
        chk("rs_wvalid_async",  64'(m_wvalid_o),  64'd0);
        chk("rs_cmd_ready",     64'(cmd_ready_o), 64'd1);
        chk("rs_rsp_valid",     64'(rsp_valid_o), 64'd0);
        #10 rst_n = 1'b1;
        step();
        chk("rs_awvalid_post", 64'(m_awvalid_o), 64'd0);

        // Watchdog with a silent slave
        exp_q.push_back('{wr: 1'b1, rdata: 32'h0, resp: RESP_TMO});
        issue(1'b1, BASE | REG_SCALER_OFS, 32'h0000_0077);
        for (int c = 1; c < int'(TMO); c++) step();
        chk("wd_awvalid_c16",   64'(m_awvalid_o),   64'd1);
        chk("wd_rsp_valid_c16", 64'(rsp_valid_o),   64'd0);
        step();
        chk("wd_rsp_valid_c17", 64'(rsp_valid_o),   64'd1);
        chk("wd_awvalid_c17",   64'(m_awvalid_o),   64'd0);
        chk("wd_wvalid_c17",    64'(m_wvalid_o),    64'd0);
        chk("wd_bready_c17",    64'(m_bready_o),    64'd0);
        chk("wd_timeout_flag",  64'(timeout_err_o), 64'd1);
        step();
        cmd_valid_i = 1'b1; cmd_wr_i = 1'b1; cmd_addr_i = BASE;
        for (int c = 0; c < 4; c++) begin
            chk("halt_cmd_ready", 64'(cmd_ready_o),   64'd0);
            chk("halt_awvalid",   64'(m_awvalid_o),   64'd0);
            chk("halt_timeout",   64'(timeout_err_o), 64'd1);
            chk("halt_rsp_valid", 64'(rsp_valid_o),   64'd0);
            step();
        end
        cmd_valid_i = 1'b0; cmd_wr_i = 1'b0; cmd_addr_i = '0;
        #2 rst_n = 1'b0;
        #1;
        chk("halt_rst_cmd_ready", 64'(cmd_ready_o),   64'd1);
        chk("halt_rst_timeout",   64'(timeout_err_o), 64'd0);
        #5 rst_n = 1'b1;
        step();
        step();

        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
